// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: serial transmit stage fed by a fall-through TX byte FIFO.
// Pops one word whenever the FIFO is non-empty. Each word goes out as a UART frame:
// a start bit, then PAYLOAD_BITS data bits LSB first, then STOP_BITS stop bits.
// The idle line is high.
// Ports:
//   clk            system clock, all logic on posedge
//   reset          synchronous, active-high
//   fifo_empty     upstream FIFO empty flag
//   fifo_read_data FIFO head word, valid while !fifo_empty
//   fifo_read      registered pop request, one-cycle pulse per word
//   tx             registered serial output
//   busy           high while a frame is on the line
module uart_fifo_tx #(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned BIT_RATE     = 115200,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fifo_empty,
  input  logic [PAYLOAD_BITS-1:0] fifo_read_data,
  output logic                    fifo_read,
  output logic                    tx,
  output logic                    busy
);

  // Clocks per bit; callers must keep CLK_FREQ/BIT_RATE >= 2
  localparam int unsigned CPB   = CLK_FREQ / BIT_RATE;
  localparam int unsigned CNT_W = $clog2(CPB * STOP_BITS) + 1;
  localparam int unsigned IDX_W = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CPB * STOP_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PAYLOAD_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    rd_q, rd_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
    end
  end

  // Next-state: tx only moves on E0 or a baud-counter terminal count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    rd_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Head is latched now; the pop lands one cycle later
        if (!fifo_empty) begin
          shift_d = fifo_read_data;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          rd_d    = 1'b1;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      START: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            tx_d  = shift_q[idx_q + IDX_W'(1)];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == STOP_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fifo_read = rd_q;
  assign tx        = tx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Testbench for uart_fifo_tx: two instances (1 and 2 stop bits) share clock, reset and
// pushed bytes. Each has its own queue-backed FIFO and a frame-position reference model.
module tb_uart_fifo_tx;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned BIT_RATE = 125_000;
  localparam int CPB = 8;
  localparam int FL0 = (1 + 8 + 1) * CPB;   // 80
  localparam int FL1 = (1 + 8 + 2) * CPB;   // 88

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fe   [2];
  logic [7:0] fd   [2];
  logic       rd_o [2];
  logic       tx_o [2];
  logic       bz_o [2];

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  int         n_vec = 0;
  int         n_bad = 0;

  // Reference model: frame position (0 = idle, 1..FL = cycle within frame)
  int         pos  [2];
  logic [7:0] mb   [2];
  logic       erd  [2];
  bit         armed = 1'b0;

  always #5 clk = ~clk;

  uart_fifo_tx #(.CLK_FREQ(CLK_FREQ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(8), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .fifo_empty(fe[0]), .fifo_read_data(fd[0]),
    .fifo_read(rd_o[0]), .tx(tx_o[0]), .busy(bz_o[0])
  );

  uart_fifo_tx #(.CLK_FREQ(CLK_FREQ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(8), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .fifo_empty(fe[1]), .fifo_read_data(fd[1]),
    .fifo_read(rd_o[1]), .tx(tx_o[1]), .busy(bz_o[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic exp_tx(input int p, input logic [7:0] b);
    if (p == 0) return 1'b1;
    if (p <= CPB) return 1'b0;
    if (p <= 9 * CPB) return b[3'((p - 1) / CPB - 1)];
    return 1'b1;
  endfunction

  // FIFO: pop on the DUT's registered request
  always @(posedge clk) begin
    if (rd_o[0] === 1'b1) begin
      if (q0.size() > 0) void'(q0.pop_front());
      else check("pop_empty0", 32'd1, 32'd0);
    end
    if (rd_o[1] === 1'b1) begin
      if (q1.size() > 0) void'(q1.pop_front());
      else check("pop_empty1", 32'd1, 32'd0);
    end
  end

  // FIFO outputs settle on the falling edge
  always @(negedge clk) begin
    fe[0] = (q0.size() == 0);
    fd[0] = (q0.size() > 0) ? q0[0] : 8'h00;
    fe[1] = (q1.size() == 0);
    fd[1] = (q1.size() > 0) ? q1[0] : 8'h00;
  end

  // Reference model advances on the same inputs the DUTs see
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        pos[i] = 0;
        erd[i] = 1'b0;
      end else if (pos[i] == 0) begin
        erd[i] = 1'b0;
        if (!fe[i]) begin
          mb[i]  = fd[i];
          pos[i] = 1;
          erd[i] = 1'b1;
        end
      end else begin
        erd[i] = 1'b0;
        pos[i] = (pos[i] == ((i == 0) ? FL0 : FL1)) ? 0 : pos[i] + 1;
      end
    end
    armed = 1'b1;
  end

  // Compare every output of both instances each cycle
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("tx%0d", i), 32'(tx_o[i]), 32'(exp_tx(pos[i], mb[i])));
        check($sformatf("busy%0d", i), 32'(bz_o[i]), 32'(pos[i] != 0));
        check($sformatf("fifo_read%0d", i), 32'(rd_o[i]), 32'(erd[i]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    q0.push_back(b);
    q1.push_back(b);
  endtask

  task automatic wait_pop0(input string tag);
    int k;
    k = 0;
    while (rd_o[0] !== 1'b1 && k < 300) begin
      tick(1);
      k++;
    end
    check(tag, 32'(rd_o[0]), 32'd1);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || bz_o[0] !== 1'b0 || bz_o[1] !== 1'b0) && k < 5000) begin
      tick(1);
      k++;
    end
    check(tag, 32'(q0.size() + q1.size()), 32'd0);
  endtask

  initial begin
    fe[0] = 1'b1; fe[1] = 1'b1;
    fd[0] = 8'h00; fd[1] = 8'h00;
    reset = 1'b1;
    tick(2);

    // Reset held with FIFO non-empty; 0xA5 frame follows release
    push(8'hA5);
    tick(4);
    reset = 1'b0;
    drain("drain_a5");
    tick(3);

    // Back-to-back 0x00, 0xFF, 0x55, then 0x7E for stop-bit spacing
    push(8'h00); push(8'hFF); push(8'h55); push(8'h7E);
    drain("drain_b2b");

    // Long empty stretch
    tick(500);
    check("idle_tx0", 32'(tx_o[0]), 32'd1);
    check("idle_busy1", 32'(bz_o[1]), 32'd0);

    // Reset during data bit 3 of 0x3C, 0x81 queued
    push(8'h3C);
    wait_pop0("pop_3c");
    tick(35);
    reset = 1'b1;
    push(8'h81);
    tick(2);
    reset = 1'b0;
    drain("drain_81");

    // Randomized traffic with occasional resets
    for (int it = 0; it < 40; it++) begin
      tick($urandom_range(0, 120));
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        tick($urandom_range(1, 3));
        reset = 1'b0;
      end
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) push(8'($urandom));
    end
    drain("drain_rand");
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
